// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   localparam int DEF_WIDTH = 4;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/div4_seq_trial_sub.sv
// Trial subtraction R' - D done as R' + ~D + 1 over WIDTH+1 bits.
module trial_sub
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH:0]   rp_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] t_o,
   output logic             borrow_o
);

   logic [WIDTH:0] d_inv;
   logic [WIDTH:0] sum;

   // D is zero-extended before inverting so the top bit reads as a borrow
   assign d_inv = ~{1'b0, d_i};
   assign sum   = rp_i + d_inv + {{WIDTH{1'b0}}, 1'b1};

   assign {borrow_o, t_o} = sum;

endmodule

// File: rtl/div4_seq.sv
// Restoring unsigned divider, one quotient bit per clock, start/done handshake.
module div4_seq
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = cnt_width(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   rp;
   logic [WIDTH-1:0] t;
   logic             borrow;
   logic             accept;
   logic             last;

   assign accept = start && (state_q != RUN);
   assign last   = (cnt_q == CW'(WIDTH - 1));
   assign rp     = {r_q, q_q[WIDTH-1]};

   trial_sub #(
      .WIDTH    (WIDTH)
   ) u_sub (
      .rp_i     (rp),
      .d_i      (d_q),
      .t_o      (t),
      .borrow_o (borrow)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = (divisor == '0) ? DONE : RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (last) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      q_d    = q_q;
      r_d    = r_q;
      d_d    = d_q;
      cnt_d  = cnt_q;
      dz_d   = dz_q;
      quot_d = quot_q;
      rem_d  = rem_q;
      dbz_d  = dbz_q;
      done_d = 1'b0;

      // Results are published one cycle after DONE is entered
      if (state_q == DONE) begin
         done_d = 1'b1;
         dbz_d  = dz_q;
         quot_d = dz_q ? '1 : q_q;
         rem_d  = dz_q ? q_q : r_q;
      end

      if (accept) begin
         d_d   = divisor;
         q_d   = dividend;
         r_d   = '0;
         cnt_d = '0;
         dz_d  = (divisor == '0);
      end else if (state_q == RUN) begin
         q_d   = {q_q[WIDTH-2:0], ~borrow};
         r_d   = borrow ? rp[WIDTH-1:0] : t;
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q    <= '0;
         r_q    <= '0;
         d_q    <= '0;
         cnt_q  <= '0;
         dz_q   <= 1'b0;
         quot_q <= '0;
         rem_q  <= '0;
         dbz_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         r_q    <= r_d;
         d_q    <= d_d;
         cnt_q  <= cnt_d;
         dz_q   <= dz_d;
         quot_q <= quot_d;
         rem_q  <= rem_d;
         dbz_q  <= dbz_d;
         done_q <= done_d;
      end
   end

   always_comb begin
      busy        = (state_q == RUN);
      done        = done_q;
      quotient    = quot_q;
      remainder   = rem_q;
      div_by_zero = dbz_q;
   end

endmodule
